// File: rtl/async_fifo_param.sv
`default_nettype none
// ==== async_fifo_param : parameterised dual-clock FIFO (gray-pointer CDC) == Rev 1.0 ====
// ==== Define ASYNC_FIFO_FWFT_EN for a first-word-fall-through read port.            ====
module async_fifo_param #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  write_clk,
   input  logic                  reset,
   input  logic                  read_clk,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  underflow
);
   localparam int                DEPTH         = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_afull_lvl  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] c_aempty_lvl = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b[ADDR_WIDTH] = g[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // ---------------- write domain ----------------
   logic [ADDR_WIDTH:0] wptr_q, wptr_d, wgray_q, wgray_d, wr_level_q, wr_level_d, rgray_s;
   logic [ADDR_WIDTH:0] rgray_sync_q [SYNC_STAGES];
   logic                full_q, full_d, overflow_q, overflow_d, push;

   // rgray_q is declared with the read domain; only its registered value is synchronised
   logic [ADDR_WIDTH:0] rgray_q;

   always_comb begin
      rgray_s    = rgray_sync_q[SYNC_STAGES-1];
      push       = write_enable && !full_q;
      wptr_d     = wptr_q + (ADDR_WIDTH+1)'(push);
      wgray_d    = bin2gray(wptr_d);
      full_d     = wgray_d == {~rgray_s[ADDR_WIDTH -: 2], rgray_s[ADDR_WIDTH-2:0]};
      wr_level_d = wptr_d - gray2bin(rgray_s);
      overflow_d = write_enable && full_q;
   end

   always_ff @(posedge write_clk) begin
      if (reset) begin
         wptr_q     <= '0;
         wgray_q    <= '0;
         wr_level_q <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) rgray_sync_q[i] <= '0;
      end else begin
         wptr_q     <= wptr_d;
         wgray_q    <= wgray_d;
         wr_level_q <= wr_level_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         rgray_sync_q[0] <= rgray_q;
         for (int i = 1; i < SYNC_STAGES; i++) rgray_sync_q[i] <= rgray_sync_q[i-1];
      end
   end

   // storage is never cleared; only the pointers define what is queued
   always_ff @(posedge write_clk) begin
      if (push && !reset) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= write_data;
   end

   // ---------------- read domain ----------------
   logic [1:0]            rst_sync_q;
   logic                  rd_rst;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d, rgray_d, rd_level_q, rd_level_d, wgray_s;
   logic [ADDR_WIDTH:0]   wgray_sync_q [SYNC_STAGES];
   logic                  mem_empty_q, mem_empty_d, valid_q, valid_d, underflow_q, underflow_d, fetch;
   logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

   always_ff @(posedge read_clk) rst_sync_q <= {rst_sync_q[0], reset};
   assign rd_rst = rst_sync_q[1];

   always_comb begin
      wgray_s = wgray_sync_q[SYNC_STAGES-1];
`ifdef ASYNC_FIFO_FWFT_EN
      // refill the output register when it is empty or being acknowledged
      fetch       = !mem_empty_q && (!valid_q || read_enable);
      valid_d     = fetch || (valid_q && !read_enable);
      underflow_d = read_enable && !valid_q;
`else
      fetch       = read_enable && !mem_empty_q;
      valid_d     = fetch;
      underflow_d = read_enable && mem_empty_q;
`endif
      rptr_d      = rptr_q + (ADDR_WIDTH+1)'(fetch);
      rgray_d     = bin2gray(rptr_d);
      mem_empty_d = rgray_d == wgray_s;
      read_data_d = fetch ? mem_q[rptr_q[ADDR_WIDTH-1:0]] : read_data_q;
`ifdef ASYNC_FIFO_FWFT_EN
      rd_level_d  = gray2bin(wgray_s) - rptr_d + (ADDR_WIDTH+1)'(valid_d);
`else
      rd_level_d  = gray2bin(wgray_s) - rptr_d;
`endif
   end

   always_ff @(posedge read_clk) begin
      if (rd_rst) begin
         rptr_q      <= '0;
         rgray_q     <= '0;
         rd_level_q  <= '0;
         mem_empty_q <= 1'b1;
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
         read_data_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) wgray_sync_q[i] <= '0;
      end else begin
         rptr_q      <= rptr_d;
         rgray_q     <= rgray_d;
         rd_level_q  <= rd_level_d;
         mem_empty_q <= mem_empty_d;
         valid_q     <= valid_d;
         underflow_q <= underflow_d;
         read_data_q <= read_data_d;
         wgray_sync_q[0] <= wgray_q;
         for (int i = 1; i < SYNC_STAGES; i++) wgray_sync_q[i] <= wgray_sync_q[i-1];
      end
   end

   assign full         = full_q;
   assign almost_full  = wr_level_q >= c_afull_lvl;
   assign wr_level     = wr_level_q;
   assign overflow     = overflow_q;
   assign read_data    = read_data_q;
   assign valid        = valid_q;
`ifdef ASYNC_FIFO_FWFT_EN
   assign empty        = !valid_q;
`else
   assign empty        = mem_empty_q;
`endif
   assign almost_empty = rd_level_q <= c_aempty_lvl;
   assign rd_level     = rd_level_q;
   assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_param.sv
`timescale 1ns/1ps
`default_nettype none
// tb_async_fifo_param: directed + random checks of async_fifo_param against a queue model.
module tb_async_fifo_param;
   localparam int DW = 8, AW = 4, DEPTH = 16;

   logic          write_clk = 1'b0, read_clk = 1'b0, reset = 1'b1;
   logic          write_enable = 1'b0, read_enable = 1'b0;
   logic [DW-1:0] write_data = '0;
   logic          full, almost_full, overflow, valid, empty, almost_empty, underflow;
   logic [AW:0]   wr_level, rd_level;
   logic [DW-1:0] read_data;

   realtime       rd_half = 7.0;
   int            n_assert = 0, n_fail = 0, sent = 0, recv = 0;
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] last_data = '0;
   logic          got;

   async_fifo_param dut (
      .write_clk(write_clk), .reset(reset), .read_clk(read_clk),
      .write_enable(write_enable), .write_data(write_data),
      .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow),
      .read_enable(read_enable), .read_data(read_data), .valid(valid), .empty(empty),
      .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
   );

   always #5 write_clk = ~write_clk;
   initial forever #(rd_half) read_clk = ~read_clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wr(input int n);
      repeat (n) @(negedge write_clk);
   endtask

   task automatic wait_rd(input int n);
      repeat (n) @(negedge read_clk);
   endtask

   // one push; the model accepts it only if the FIFO holds fewer than DEPTH words
   task automatic push(input logic [DW-1:0] d);
      logic exp_ovf;
      @(negedge write_clk);
      write_enable = 1'b1;
      write_data   = d;
      exp_ovf      = model_q.size() >= DEPTH;
      if (!exp_ovf) model_q.push_back(d);
      @(negedge write_clk);
      write_enable = 1'b0;
      check("overflow_on_push", overflow, exp_ovf);
   endtask

`ifndef ASYNC_FIFO_FWFT_EN
   task automatic pop();
      logic exp_uf;
      @(negedge read_clk);
      read_enable = 1'b1;
      exp_uf      = model_q.size() == 0;
      if (!exp_uf) last_data = model_q.pop_front();
      @(negedge read_clk);
      read_enable = 1'b0;
      check("pop_valid", valid, !exp_uf);
      check("pop_underflow", underflow, exp_uf);
      check("pop_data", read_data, last_data);
   endtask
`endif

   initial begin
      // ---- reset ----
      reset = 1'b1;
      wait_wr(10);
      reset = 1'b0;
      wait_rd(6);
      check("rst_full", full, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_wr_level", wr_level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_empty", empty, 1);
      check("rst_almost_empty", almost_empty, 1);
      check("rst_rd_level", rd_level, 0);
      check("rst_valid", valid, 0);
      check("rst_underflow", underflow, 0);
      check("rst_read_data", read_data, 0);

`ifdef ASYNC_FIFO_FWFT_EN
      // ---- first-word-fall-through ----
      push(8'h5A);
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         @(negedge read_clk);
         got = valid;
      end
      check("fwft_valid", valid, 1);
      check("fwft_data", read_data, 8'h5A);
      check("fwft_rd_level", rd_level, 1);
      check("fwft_empty", empty, 0);
      @(negedge read_clk);
      check("fwft_hold_valid", valid, 1);
      read_enable = 1'b1;
      @(negedge read_clk);
      read_enable = 1'b0;
      void'(model_q.pop_front());
      check("fwft_ack_valid", valid, 0);
      check("fwft_ack_empty", empty, 1);
      check("fwft_ack_underflow", underflow, 0);
      read_enable = 1'b1;
      @(negedge read_clk);
      read_enable = 1'b0;
      check("fwft_underflow", underflow, 1);
      @(negedge read_clk);
      check("fwft_underflow_pulse", underflow, 0);
`else
      // ---- fill to full, then one rejected push ----
      for (int i = 1; i <= DEPTH; i++) begin
         push(8'(i));
         check("fill_wr_level", wr_level, model_q.size());
         check("fill_full", full, model_q.size() == DEPTH);
         check("fill_almost_full", almost_full, model_q.size() >= DEPTH - 2);
      end
      push(8'hFF);
      check("ovf_full_kept", full, 1);
      check("ovf_wr_level", wr_level, DEPTH);
      @(negedge write_clk);
      check("ovf_single_pulse", overflow, 0);

      // ---- drain plus one underflow ----
      wait_rd(6);
      for (int i = 1; i <= DEPTH + 1; i++) begin
         pop();
         check("drain_empty", empty, model_q.size() == 0);
      end
      check("drain_hold_data", read_data, 8'h10);
      wait_wr(8);
      check("drain_wr_level", wr_level, 0);
      check("drain_full", full, 0);

      // ---- random traffic with a slower read clock ----
      rd_half = 11.5;
      wait_rd(2);
      fork
         begin
            for (int cyc = 0; cyc < 20000 && sent < 100; cyc++) begin
               @(negedge write_clk);
               check("rand_overflow", overflow, 0);
               if (!full && $urandom_range(0, 1) == 1) begin
                  write_enable = 1'b1;
                  write_data   = 8'($urandom);
                  model_q.push_back(write_data);
                  sent++;
               end else begin
                  write_enable = 1'b0;
               end
            end
            @(negedge write_clk);
            write_enable = 1'b0;
         end
         begin
            for (int cyc = 0; cyc < 4000 && recv < 100; cyc++) begin
               @(negedge read_clk);
               check("rand_underflow", underflow, 0);
               check("rand_full_and_empty", full & empty, 0);
               if (valid) begin
                  if (model_q.size() == 0) check("rand_unexpected_valid", valid, 0);
                  else check("rand_data", read_data, model_q.pop_front());
                  recv++;
               end
               read_enable = !empty && ($urandom_range(0, 1) == 1);
            end
            read_enable = 1'b0;
         end
      join
      check("rand_words_received", recv, 100);
      last_data = read_data;
      rd_half = 7.0;
      wait_rd(4);
      wait_wr(8);

      // ---- almost_empty threshold ----
      push(8'h31);
      push(8'h32);
      push(8'h33);
      wait_rd(6);
      check("ae_rd_level3", rd_level, model_q.size());
      check("ae_deasserted", almost_empty, 0);
      pop();
      check("ae_rd_level2", rd_level, model_q.size());
      check("ae_reasserted", almost_empty, model_q.size() <= 2);
      pop();
      pop();
      check("ae_empty", empty, 1);
      wait_wr(8);

      // ---- mid-operation reset ----
      for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
      @(negedge write_clk);
      reset        = 1'b1;
      write_enable = 1'b1;
      write_data   = 8'hEE;
      repeat (6) begin
         @(negedge write_clk);
         check("rst_push_no_overflow", overflow, 0);
      end
      reset        = 1'b0;
      write_enable = 1'b0;
      model_q.delete();
      last_data = '0;
      wait_rd(6);
      check("mrst_empty", empty, 1);
      check("mrst_wr_level", wr_level, 0);
      check("mrst_rd_level", rd_level, 0);
      check("mrst_full", full, 0);
      check("mrst_read_data", read_data, 0);
      push(8'hA5);
      wait_rd(6);
      pop();
      pop();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
